// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier with per-transaction signed/unsigned mode.
// Stages: operand register, Baugh-Wooley carry-save reduction, carry-propagate add.
module wallace_mult_pipe #(
   parameter int unsigned WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int          NROWS = int'(WIDTH) + 1;

   // Baugh-Wooley correction: +2^WIDTH and +2^(PW-1), modulo 2^PW.
   localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

   function automatic int num_levels(input int rows);
      int n;
      int lv;
      n  = rows;
      lv = 0;
      while (n > 2) begin
         n  = 2 * (n / 3) + n % 3;
         lv = lv + 1;
      end
      return lv;
   endfunction

   localparam int LEVELS = num_levels(NROWS);

   logic             stall;
   logic             advance;
   logic             accept;

   logic             s0_valid_q;
   logic [WIDTH-1:0] s0_a_q;
   logic [WIDTH-1:0] s0_b_q;
   logic             s0_signed_q;

   logic             s1_valid_q;
   logic [PW-1:0]    s1_sum_q;
   logic [PW-1:0]    s1_carry_q;

   logic             out_valid_q;
   logic [PW-1:0]    out_p_q;

   logic [PW-1:0]    pp [NROWS];
   logic [PW-1:0]    red_sum;
   logic [PW-1:0]    red_carry;

   assign stall    = out_valid_q & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = ~stall;
   assign accept   = in_valid & ~stall;

   // Mixed-sign products (exactly one index at the MSB) are inverted in signed mode.
   always_comb begin
      logic pbit;
      for (int i = 0; i < NROWS; i++) pp[i] = '0;
      pbit = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         for (int j = 0; j < int'(WIDTH); j++) begin
            pbit = s0_a_q[j] & s0_b_q[i];
            if (s0_signed_q && ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1))) begin
               pbit = ~pbit;
            end
            pp[i] = pp[i] | (PW'(pbit) << (i + j));
         end
      end
      if (s0_signed_q) pp[WIDTH] = CORR;
   end

   // Each layer maps every full group of three rows to a sum row and a shifted carry row;
   // the one or two leftover rows pass straight through to the next layer.
   always_comb begin : reduce
      logic [PW-1:0] cur [NROWS];
      logic [PW-1:0] nxt [NROWS];
      int            n;
      int            grp;
      for (int k = 0; k < NROWS; k++) begin
         cur[k] = pp[k];
         nxt[k] = '0;
      end
      n   = NROWS;
      grp = 0;
      for (int l = 0; l < LEVELS; l++) begin
         grp = n / 3;
         for (int k = 0; k < NROWS; k++) nxt[k] = '0;
         for (int g = 0; g < NROWS / 3; g++) begin
            if (g < grp) begin
               nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
               nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                             (cur[3*g+1] & cur[3*g+2])) << 1;
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (3 * grp + k < n) nxt[2*grp + k] = cur[3*grp + k];
         end
         for (int k = 0; k < NROWS; k++) cur[k] = nxt[k];
         n = 2 * grp + n % 3;
      end
      red_sum   = cur[0];
      red_carry = cur[1];
   end

   // Whole pipe freezes on stall; data registers only load behind a valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_q  <= 1'b0;
         s0_a_q      <= '0;
         s0_b_q      <= '0;
         s0_signed_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_carry_q  <= '0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
      end else if (advance) begin
         s0_valid_q  <= accept;
         if (accept) begin
            s0_a_q      <= in_a;
            s0_b_q      <= in_b;
            s0_signed_q <= in_signed;
         end
         s1_valid_q  <= s0_valid_q;
         if (s0_valid_q) begin
            s1_sum_q   <= red_sum;
            s1_carry_q <= red_carry;
         end
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) out_p_q <= s1_sum_q + s1_carry_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign busy      = s0_valid_q | s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed and scoreboard bench for wallace_mult_pipe at WIDTH=6 and WIDTH=8.
module tb_wallace_mult_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid6, in_ready6, in_signed6, out_valid6, out_ready6, busy6;
   logic [5:0]  in_a6, in_b6;
   logic [11:0] out_p6;

   logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
   logic [7:0]  in_a8, in_b8;
   logic [15:0] out_p8;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] q6 [$];
   logic [63:0] q8 [$];

   logic [5:0] st_a [8] = '{6'h3F, 6'h20, 6'h15, 6'h01, 6'h2A, 6'h1F, 6'h00, 6'h33};
   logic [5:0] st_b [8] = '{6'h3F, 6'h20, 6'h0B, 6'h3F, 6'h11, 6'h1F, 6'h2C, 6'h07};
   logic       st_s [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   wallace_mult_pipe #(.WIDTH(6)) u_dut6 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid6),
      .in_ready  (in_ready6),
      .in_a      (in_a6),
      .in_b      (in_b6),
      .in_signed (in_signed6),
      .out_valid (out_valid6),
      .out_ready (out_ready6),
      .out_p     (out_p6),
      .busy      (busy6)
   );

   wallace_mult_pipe #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_a      (in_a8),
      .in_b      (in_b8),
      .in_signed (in_signed8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out_p     (out_p8),
      .busy      (busy8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: extend operands to 64 bits and multiply, keep 2*w bits.
   function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic s);
      longint sa;
      longint sb;
      logic [63:0] p;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      p = 64'(sa * sb);
      return p & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run6(input string tag, input logic [5:0] a, input logic [5:0] b,
                       input logic s, input logic [11:0] exp);
      in_valid6 = 1'b1; in_a6 = a; in_b6 = b; in_signed6 = s; out_ready6 = 1'b1;
      step();
      in_valid6 = 1'b0; in_a6 = ~a; in_b6 = ~b; in_signed6 = ~s;
      check({tag, "_lat1"}, 64'(out_valid6), 64'd0);
      step();
      check({tag, "_lat2"}, 64'(out_valid6), 64'd0);
      step();
      check({tag, "_valid"}, 64'(out_valid6), 64'd1);
      check({tag, "_p"}, 64'(out_p6), 64'(exp));
      step();
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp);
      in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_signed8 = s; out_ready8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      step();
      step();
      check({tag, "_valid"}, 64'(out_valid8), 64'd1);
      check({tag, "_p"}, 64'(out_p8), 64'(exp));
      step();
   endtask

   initial begin
      int first;
      int last;
      int got;
      int stale;
      rst_n = 1'b0;
      in_valid6 = 1'b0; in_a6 = '0; in_b6 = '0; in_signed6 = 1'b0; out_ready6 = 1'b0;
      in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; out_ready8 = 1'b0;
      #12;
      check("rst_out_valid", 64'(out_valid6), 64'd0);
      check("rst_out_p", 64'(out_p6), 64'd0);
      check("rst_busy", 64'(busy6), 64'd0);
      check("rst_in_ready", 64'(in_ready6), 64'd1);
      rst_n = 1'b1;
      step();

      run6("u63x63", 6'h3F, 6'h3F, 1'b0, 12'hF81);
      run6("u0x45", 6'h00, 6'h2D, 1'b0, 12'h000);
      run6("s_m32xm32", 6'h20, 6'h20, 1'b1, 12'h400);
      run6("s_m1x1", 6'h3F, 6'h01, 1'b1, 12'hFFF);
      run6("s_m32x31", 6'h20, 6'h1F, 1'b1, 12'hC20);

      // Back-to-back mixed-mode stream.
      out_ready6 = 1'b1; first = -1; last = -1; got = 0; q6.delete();
      for (int c = 0; c < 14; c++) begin
         if (out_valid6) begin
            if (q6.size() == 0) check("stream_extra", 64'(out_valid6), 64'd0);
            else check("stream_p", 64'(out_p6), q6.pop_front());
            if (first < 0) first = c;
            last = c;
            got++;
         end
         if (c < 8) begin
            check("stream_ready", 64'(in_ready6), 64'd1);
            in_valid6 = 1'b1; in_a6 = st_a[c]; in_b6 = st_b[c]; in_signed6 = st_s[c];
            q6.push_back(model(6, 64'(st_a[c]), 64'(st_b[c]), st_s[c]));
         end else begin
            in_valid6 = 1'b0;
         end
         step();
      end
      check("stream_count", 64'(got), 64'd8);
      check("stream_first", 64'(first), 64'd3);
      check("stream_span", 64'(last - first), 64'd7);

      // Backpressure with three in flight: 10*12=0x078, -5*6=0xFE2, 63*2=0x07E.
      out_ready6 = 1'b0;
      in_valid6 = 1'b1; in_a6 = 6'd10; in_b6 = 6'd12; in_signed6 = 1'b0; step();
      in_a6 = 6'h3B; in_b6 = 6'd6; in_signed6 = 1'b1; step();
      in_a6 = 6'd63; in_b6 = 6'd2; in_signed6 = 1'b0; step();
      in_a6 = 6'h2A; in_b6 = 6'h15; in_signed6 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", 64'(out_valid6), 64'd1);
         check("bp_p", 64'(out_p6), 64'h078);
         check("bp_in_ready", 64'(in_ready6), 64'd0);
         check("bp_busy", 64'(busy6), 64'd1);
         in_a6 = in_a6 + 6'd1;
         step();
      end
      in_valid6 = 1'b0; out_ready6 = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready6), 64'd1);
      check("bp_drain_a", 64'(out_p6), 64'h078);
      step();
      check("bp_drain_b_valid", 64'(out_valid6), 64'd1);
      check("bp_drain_b", 64'(out_p6), 64'hFE2);
      step();
      check("bp_drain_c_valid", 64'(out_valid6), 64'd1);
      check("bp_drain_c", 64'(out_p6), 64'h07E);
      step();
      check("bp_empty_valid", 64'(out_valid6), 64'd0);
      check("bp_empty_busy", 64'(busy6), 64'd0);

      // Asynchronous reset with two transactions in flight.
      in_valid6 = 1'b1; in_a6 = 6'd9; in_b6 = 6'd11; in_signed6 = 1'b0; step();
      in_a6 = 6'h3D; in_b6 = 6'd5; in_signed6 = 1'b1; step();
      in_valid6 = 1'b0; step();
      check("pre_rst_valid", 64'(out_valid6), 64'd1);
      check("pre_rst_p", 64'(out_p6), 64'd99);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid6), 64'd0);
      check("mid_rst_busy", 64'(busy6), 64'd0);
      check("mid_rst_p", 64'(out_p6), 64'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step();
      stale = 0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid6 || busy6) stale++;
         step();
      end
      check("post_rst_stale", 64'(stale), 64'd0);
      run6("post_rst_5x7", 6'd5, 6'd7, 1'b0, 12'd35);

      // WIDTH=8 boundaries and random regression.
      run8("w8_u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
      run8("w8_s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
      run8("w8_s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001);

      q8.delete();
      for (int c = 0; c < 10000; c++) begin
         in_valid8  = 1'($urandom_range(0, 1));
         in_a8      = 8'($urandom);
         in_b8      = 8'($urandom);
         in_signed8 = 1'($urandom_range(0, 1));
         out_ready8 = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) check("rand_extra", 64'(out_valid8), 64'd0);
            else check("rand_p", 64'(out_p8), q8.pop_front());
         end
         if (in_valid8 && in_ready8) q8.push_back(model(8, 64'(in_a8), 64'(in_b8), in_signed8));
         @(posedge clk);
         #1;
      end
      in_valid8 = 1'b0; out_ready8 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid8) begin
            if (q8.size() == 0) check("rand_extra", 64'(out_valid8), 64'd0);
            else check("rand_p", 64'(out_p8), q8.pop_front());
         end
         step();
      end
      check("rand_drained", 64'(q8.size()), 64'd0);
      check("rand_idle_busy", 64'(busy8), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
